// File: rtl/apb_const_rom_slave.sv
// Read-only APB completer returning pi and e as Q2.62 words, with P_WAIT wait states.
// Optional macro APB_RD_CNT_EN maps a successful-read counter at index 4.
module apb_const_rom_slave #(
  parameter logic [31:0] P_BASE = 32'h7000_0000,
  parameter int unsigned P_WAIT = 1
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(P_WAIT);

`ifdef APB_RD_CNT_EN
  localparam logic [3:0] MAX_IDX = 4'd4;
`else
  localparam logic [3:0] MAX_IDX = 4'd3;
`endif

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        hit_q, hit_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;
  logic        complete;
  logic        addr_hit;
  logic [31:0] rom_word;

`ifdef APB_RD_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
`endif

  assign addr_hit = (paddr[31:4] == P_BASE[31:4]) && (paddr[3:0] <= MAX_IDX);

  // Word lookup uses the index that will be live after this edge (fresh on a zero-wait setup).
  always_comb begin
    rom_word = 32'h0;
    case (idx_d)
      4'd0: rom_word = 32'hC90F_DAA2;
      4'd1: rom_word = 32'h2168_C234;
      4'd2: rom_word = 32'hADF8_5458;
      4'd3: rom_word = 32'hA2BB_4A9A;
`ifdef APB_RD_CNT_EN
      4'd4: rom_word = rd_cnt_q;
`endif
      default: rom_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = 32'h0;
    complete  = 1'b0;
`ifdef APB_RD_CNT_EN
    rd_cnt_d  = rd_cnt_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (psel && !penable) begin
          state_d = ACCESS;
          idx_d   = paddr[3:0];
          hit_d   = addr_hit;
          cnt_d   = WAIT_INIT;
          complete = (WAIT_INIT == 4'd0);
        end
      end
      ACCESS: begin
        // A completion already on the bus finishes regardless of psel.
        if (pready_q) begin
          state_d = DONE;
        end else if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q <= 4'd1) begin
            cnt_d    = 4'd0;
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      pready_d = 1'b1;
      if (hit_d) begin
        prdata_d = rom_word;
`ifdef APB_RD_CNT_EN
        if (idx_d < 4'd4) begin
          rd_cnt_d = rd_cnt_q + 32'd1;
        end
`endif
      end else begin
        pslverr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= 4'd0;
      hit_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'h0;
`ifdef APB_RD_CNT_EN
      rd_cnt_q  <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
`ifdef APB_RD_CNT_EN
      rd_cnt_q  <= rd_cnt_d;
`endif
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_const_rom_slave.sv
// Directed bench for apb_const_rom_slave: three instances built with P_WAIT = 0, 1 and 3.
// Counter checks are compiled in when APB_RD_CNT_EN is defined.
module tb_apb_const_rom_slave;

  logic        pclk;
  logic        presetn;
  logic        penable;
  logic [31:0] paddr;
  logic        psel0, psel1, psel3;
  logic [31:0] prdata0, prdata1, prdata3;
  logic        pready0, pready1, pready3;
  logic        pslverr0, pslverr1, pslverr3;

  int checks = 0;
  int errors = 0;
  logic [31:0] lastData;

`ifdef APB_RD_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  apb_const_rom_slave #(.P_BASE(32'h7000_0000), .P_WAIT(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .paddr(paddr),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_const_rom_slave #(.P_BASE(32'h7000_0000), .P_WAIT(1)) dut1 (
    .pclk(pclk), .presetn(presetn), .psel(psel1), .penable(penable), .paddr(paddr),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  apb_const_rom_slave #(.P_BASE(32'h7000_0000), .P_WAIT(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable), .paddr(paddr),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic getOut(input int k, output logic [31:0] d, output logic r, output logic e);
    case (k)
      0:       begin d = prdata0; r = pready0; e = pslverr0; end
      1:       begin d = prdata1; r = pready1; e = pslverr1; end
      default: begin d = prdata3; r = pready3; e = pslverr3; end
    endcase
  endtask

  task automatic setSel(input int k, input logic v);
    case (k)
      0:       psel0 = v;
      1:       psel1 = v;
      default: psel3 = v;
    endcase
  endtask

  task automatic nextCycle();
    @(posedge pclk);
    #1;
  endtask

  // Full read on instance k; returns one cycle into DONE with the bus idle, so an immediate
  // second call issues its setup back-to-back.
  task automatic applyStimulus(input int k, input logic [31:0] addr, input logic [31:0] expData,
                               input logic expErr, input int expCyc, input string tag);
    logic [31:0] d;
    logic r, e;
    int cyc;
    getOut(k, d, r, e);
    checkOutput({tag, "_pre_pready"}, {31'b0, r}, 32'h0);
    setSel(k, 1'b1);
    penable = 1'b0;
    paddr = addr;
    nextCycle();
    penable = 1'b1;
    paddr = 32'hFFFF_FFFF;
    cyc = 1;
    getOut(k, d, r, e);
    while (!r && cyc <= 20) begin
      nextCycle();
      cyc++;
      getOut(k, d, r, e);
    end
    lastData = d;
    checkOutput({tag, "_cycles"}, 32'(cyc), 32'(expCyc));
    checkOutput({tag, "_prdata"}, d, expData);
    checkOutput({tag, "_pslverr"}, {31'b0, e}, {31'b0, expErr});
    nextCycle();
    getOut(k, d, r, e);
    checkOutput({tag, "_done_pready"}, {31'b0, r}, 32'h0);
    checkOutput({tag, "_done_prdata"}, d, 32'h0);
    setSel(k, 1'b0);
    penable = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic r, e;
    int seen;

    presetn = 1'b0;
    psel0 = 1'b0;
    psel1 = 1'b0;
    psel3 = 1'b0;
    penable = 1'b0;
    paddr = 32'h0;
    $display("[TB] reset");
    repeat (3) nextCycle();
    checkOutput("rst_prdata", prdata1, 32'h0);
    checkOutput("rst_pready", {31'b0, pready1}, 32'h0);
    checkOutput("rst_pslverr", {31'b0, pslverr1}, 32'h0);
    checkOutput("rst_pready0", {31'b0, pready0}, 32'h0);
    presetn = 1'b1;
    nextCycle();

    $display("[TB] map reads, P_WAIT=1");
    applyStimulus(1, 32'h7000_0000, 32'hC90F_DAA2, 1'b0, 2, "pi_high"); nextCycle();
    applyStimulus(1, 32'h7000_0001, 32'h2168_C234, 1'b0, 2, "pi_low");  nextCycle();
    applyStimulus(1, 32'h7000_0002, 32'hADF8_5458, 1'b0, 2, "e_high");
    checkOutput("e_high_int", {30'b0, lastData[31:30]}, 32'h2);
    nextCycle();
    applyStimulus(1, 32'h7000_0003, 32'hA2BB_4A9A, 1'b0, 2, "e_low");   nextCycle();
    applyStimulus(1, 32'h7000_0007, 32'h0, 1'b1, 2, "err_idx7");       nextCycle();
    applyStimulus(1, 32'h7100_0000, 32'h0, 1'b1, 2, "err_base");       nextCycle();
    if (CNT_EN) applyStimulus(1, 32'h7000_0004, 32'd4, 1'b0, 2, "idx4_cnt");
    else        applyStimulus(1, 32'h7000_0004, 32'h0, 1'b1, 2, "idx4_err");
    nextCycle();

    $display("[TB] back-to-back, P_WAIT=0 and P_WAIT=3");
    applyStimulus(0, 32'h7000_0001, 32'h2168_C234, 1'b0, 1, "w0_a");
    applyStimulus(0, 32'h7000_0001, 32'h2168_C234, 1'b0, 1, "w0_b");
    nextCycle();
    applyStimulus(2, 32'h7000_0001, 32'h2168_C234, 1'b0, 4, "w3_a");
    applyStimulus(2, 32'h7000_0001, 32'h2168_C234, 1'b0, 4, "w3_b");
    nextCycle();

    $display("[TB] penable without setup");
    psel1 = 1'b1;
    penable = 1'b1;
    paddr = 32'h7000_0000;
    seen = 0;
    repeat (4) begin
      nextCycle();
      if (pready1) seen++;
    end
    checkOutput("no_setup_pready", 32'(seen), 32'h0);
    psel1 = 1'b0;
    penable = 1'b0;
    nextCycle();

    $display("[TB] psel dropped mid-access");
    psel3 = 1'b1;
    paddr = 32'h7000_0000;
    nextCycle();
    penable = 1'b1;
    nextCycle();
    psel3 = 1'b0;
    penable = 1'b0;
    seen = 0;
    repeat (6) begin
      nextCycle();
      if (pready3) seen++;
    end
    checkOutput("abort_pready", 32'(seen), 32'h0);
    checkOutput("abort_prdata", prdata3, 32'h0);
    applyStimulus(2, 32'h7000_0002, 32'hADF8_5458, 1'b0, 4, "w3_recover");
    nextCycle();

    $display("[TB] reset during wait state");
    psel1 = 1'b1;
    paddr = 32'h7000_0000;
    nextCycle();
    penable = 1'b1;
    presetn = 1'b0;
    #1;
    getOut(1, d, r, e);
    checkOutput("midrst_pready", {31'b0, r}, 32'h0);
    checkOutput("midrst_prdata", d, 32'h0);
    checkOutput("midrst_pslverr", {31'b0, e}, 32'h0);
    seen = 0;
    repeat (2) begin
      nextCycle();
      if (pready1) seen++;
    end
    psel1 = 1'b0;
    penable = 1'b0;
    presetn = 1'b1;
    repeat (2) begin
      nextCycle();
      if (pready1) seen++;
    end
    checkOutput("midrst_no_pready", 32'(seen), 32'h0);
    applyStimulus(1, 32'h7000_0000, 32'hC90F_DAA2, 1'b0, 2, "post_rst");
    nextCycle();

`ifdef APB_RD_CNT_EN
    $display("[TB] read counter");
    applyStimulus(1, 32'h7000_0001, 32'h2168_C234, 1'b0, 2, "cnt_rd2"); nextCycle();
    applyStimulus(1, 32'h7000_0002, 32'hADF8_5458, 1'b0, 2, "cnt_rd3"); nextCycle();
    applyStimulus(1, 32'h7000_0009, 32'h0, 1'b1, 2, "cnt_err");         nextCycle();
    applyStimulus(1, 32'h7000_0004, 32'd3, 1'b0, 2, "cnt_three");       nextCycle();
    force dut1.rd_cnt_q = 32'hFFFF_FFFF;
    nextCycle();
    release dut1.rd_cnt_q;
    nextCycle();
    applyStimulus(1, 32'h7000_0003, 32'hA2BB_4A9A, 1'b0, 2, "cnt_wrap_rd"); nextCycle();
    applyStimulus(1, 32'h7000_0004, 32'h0, 1'b0, 2, "cnt_wrap");         nextCycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_const_rom_slave.md
Name: apb_const_rom_slave

Overview:
- Read-only APB completer serving the mathematical constants pi and e as 64-bit Q2.62 fixed-point values, each split into high/low 32-bit words.
- Sits at the device window based at 32'h7000_0000 on the peripheral bus and answers the bus initiator's read transfers.
- Inserts a programmable number of wait states.
- Flags out-of-range addresses with pslverr.

Parameters:
- P_BASE, 32'h7000_0000, device base address; decode compares paddr[31:4] against P_BASE[31:4].
- P_WAIT, 1, wait states inserted in the access phase; legal range 0..15.

Ports:
- pclk  input  1  bus clock; all state updates on its rising edge.
- presetn  input  1  asynchronous active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB enable; high marks the access phase.
- paddr  input  32  word-indexed address; index = paddr[3:0].
- prdata  output  32  read data; valid only while pready=1.
- pready  output  1  transfer-complete strobe.
- pslverr  output  1  error response; valid only while pready=1.

Interface (already decided): one clock, pclk; reset presetn is asynchronous and active-low.

Behaviour:
- Reset (presetn=0, asynchronous) forces:
  - pready=0, pslverr=0, prdata=32'h0.
  - FSM to IDLE; wait counter = 0; latched index = 0.
- Reset asserted mid-transfer aborts it; no pready is issued for that transfer.
- All outputs are registered.
- pready is 0 whenever no completion is being signalled, including idle. The initiator waits for pready==0 before starting a transfer.
- Register map (index, word):
  - 0: pi_high = 32'hC90F_DAA2
  - 1: pi_low = 32'h2168_C234
  - 2: e_high = 32'hADF8_5458
  - 3: e_low = 32'hA2BB_4A9A
  - High word bits [31:30] are the integer part; all remaining bits are fraction, truncated.
- Decode hit requires paddr[31:4] == P_BASE[31:4] and an index listed in the map. Anything else is an error.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On an edge sampling psel=1, penable=0 (setup), latch index and hit, load counter = P_WAIT, go to ACCESS.
  - If P_WAIT=0, also set pready=1 at this same edge.
- ACCESS:
  - Each edge sampling psel=1 and penable=1 decrements the counter while it is nonzero.
  - The edge at which the counter becomes 0 (or is already 0 with pready set) drives pready=1 for one cycle.
  - Result: pready is high during access cycle P_WAIT+1, counting the first cycle with penable=1 as cycle 1.
- Completion cycle outputs:
  - Hit: prdata = map word, pslverr=0.
  - Miss: prdata = 0, pslverr=1.
  - Next edge goes to DONE with pready=0, pslverr=0, prdata=0.
- DONE returns to IDLE on the next edge. If that edge samples a new setup, it is treated exactly as a setup seen in IDLE (back-to-back transfers).
- Protocol violation (psel=0 sampled in ACCESS before completion): return to IDLE, no pready, outputs stay 0.
- paddr changes during the access phase are ignored; the index latched at setup is used.
- penable=1 sampled in IDLE without a prior setup is ignored.

Optional Feature:
- Macro: APB_RD_CNT_EN.
- Defined:
  - Index 4 is a hit and returns a 32-bit counter of completed successful reads of indices 0..3.
  - Error responses and index-4 reads are not counted.
  - The counter increments on the pready edge, wraps 32'hFFFF_FFFF -> 0, and resets to 0.
  - A read of index 4 returns the count before the current transfer.
- Not defined: index 4 is an error (pslverr=1, prdata=0); no counter logic is synthesized.

Test Plan:
- Reset, then read 0x7000_0000 with P_WAIT=1 -> pready high in the 2nd access cycle, prdata=32'hC90F_DAA2, pslverr=0; 0x7000_0001 -> 32'h2168_C234.
- Read 0x7000_0002 and 0x7000_0003 -> 32'hADF8_5458 and 32'hA2BB_4A9A; bits [31:30] of e_high = 2'b10.
- Errors:
  - Read 0x7000_0007 -> pready with pslverr=1, prdata=0.
  - Read 0x7100_0000 -> same.
  - Read 0x7000_0004 without the macro -> pslverr=1.
- P_WAIT=0 and P_WAIT=3 builds, back-to-back reads of index 1 -> pready in access cycle 1 and 4 respectively, never high in idle, one-cycle pulse.
- Assert presetn=0 during a wait state of an index-0 read -> all outputs 0 immediately, no pready; next read returns 32'hC90F_DAA2.
- With APB_RD_CNT_EN:
  - Three good reads, one error read, then index 4 -> prdata=3.
  - Force the counter to 32'hFFFF_FFFF, do one good read, read index 4 -> prdata=0.
